// File: rtl/iir_dec_buf_if.sv
// Consumer-facing stream of the IIR output buffer: FWFT head sample,
// valid/ready handshake and occupancy/overflow status.
interface iir_dec_buf_if #(
    parameter int W  = 14,
    parameter int AW = 3
);
    logic [W:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [AW:0] level;
    logic        full;
    logic        overflow;

    modport master (
        output out_data,
        output out_valid,
        output level,
        output full,
        output overflow,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  level,
        input  full,
        input  overflow,
        output out_ready
    );
endinterface

// File: rtl/iir_dec_buf.sv
// Output stage after the parallel IIR filter: drops pipeline-fill samples,
// decimates by 1/2/4/8 and buffers kept samples in a small FWFT FIFO.
module iir_dec_buf #(
    parameter int W     = 14,
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int LAT   = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [W:0]    y_in,
    input  logic          y_en,
    input  logic [1:0]    dec_sel,
    input  logic          ovf_clr,
    iir_dec_buf_if.master stream
);
    localparam int          CW        = (LAT > 0) ? $clog2(LAT + 1) : 1;
    localparam logic [CW-1:0] LAT_CNT = CW'(LAT);
    localparam logic [AW:0] DEPTH_LVL = (AW + 1)'(DEPTH);

    typedef enum logic [0:0] {
        ST_WARM,
        ST_RUN
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] warm_cnt;
    logic [CW-1:0] warm_cnt_next;
    logic          running;

    logic [1:0]    dec_q;
    logic [2:0]    phase;
    logic [2:0]    phase_max;
    logic [2:0]    phase_next;
    logic          keep;

    logic [W:0]    mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   lvl;
    logic          is_full;
    logic          is_valid;
    logic          ovf;
    logic          rd_en;
    logic          wr_en;
    logic          drop;

    // Warm-up: discard the first LAT qualified samples after reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= (LAT == 0) ? ST_RUN : ST_WARM;
            warm_cnt <= '0;
        end else begin
            state    <= state_next;
            warm_cnt <= warm_cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        warm_cnt_next = warm_cnt;
        running       = 1'b0;
        case (state)
            ST_WARM: begin
                if (y_en) begin
                    warm_cnt_next = warm_cnt + 1'b1;
                    if (warm_cnt_next == LAT_CNT) begin
                        state_next = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                running = 1'b1;
            end
            default: begin
                state_next = ST_WARM;
            end
        endcase
    end

    always_comb begin
        phase_max = '0;
        case (dec_q)
            2'd0:    phase_max = 3'd0;
            2'd1:    phase_max = 3'd1;
            2'd2:    phase_max = 3'd3;
            default: phase_max = 3'd7;
        endcase
    end

    assign keep = y_en && running && (phase == '0);

    // A change of the registered ratio restarts the interval so the next sample is kept.
    always_comb begin
        phase_next = phase;
        if (dec_sel != dec_q) begin
            phase_next = '0;
        end else if (y_en && running) begin
            phase_next = (phase == phase_max) ? '0 : phase + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            dec_q <= '0;
            phase <= '0;
        end else begin
            dec_q <= dec_sel;
            phase <= phase_next;
        end
    end

    assign lvl      = wr_ptr - rd_ptr;
    assign is_full  = (lvl == DEPTH_LVL);
    assign is_valid = (lvl != '0);
    assign rd_en    = is_valid && stream.out_ready;
    // At full, a same-cycle read frees the slot the incoming sample takes.
    assign wr_en    = keep && (!is_full || rd_en);
    assign drop     = keep && !wr_en;

    always_ff @(posedge clk) begin
        if (reset && wr_en) begin
            mem[wr_ptr[AW-1:0]] <= y_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf    <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (drop) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

    assign stream.out_data  = mem[rd_ptr[AW-1:0]];
    assign stream.out_valid = is_valid;
    assign stream.level     = lvl;
    assign stream.full      = is_full;
    assign stream.overflow  = ovf;
endmodule
